// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: buffers 16-bit samples from notes_player in a small FIFO,
// paces the player with one-cycle requests, and serializes each buffered
// sample as a 64-bclk I2S frame carrying the same sample in both slots.
module i2s_sample_tx #(
  parameter int CLK_DIV = 4,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play_enable,
  input  logic [15:0]        sample_in,
  input  logic               new_sample_ready,
  output logic               generate_next_sample,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               underflow
);

  localparam int                 DEPTH    = 2 ** FIFO_AW;
  localparam logic [7:0]         DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  // Divider and bit position
  logic [7:0]  div_q, div_d;
  logic        bclk_q, bclk_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        div_tc, shift_evt, frame_start;

  // Sample buffer
  logic signed [15:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                fifo_full, fifo_empty, push, pop;
  logic                ovf_q, ovf_d, udf_q, udf_d;

  // Request handshake
  logic        gen_q, gen_d, outst_q, outst_d;

  // Serializer
  logic signed [15:0] frame_q, frame_d;
  logic        lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic [4:0]  slot;
  logic [3:0]  bit_idx;

  // Divider: bclk toggles on terminal count; its falling toggle advances the bit counter.
  always_comb begin
    div_tc      = (div_q == DIV_LAST);
    shift_evt   = div_tc && bclk_q;
    div_d       = div_tc ? 8'd0 : div_q + 8'd1;
    bclk_d      = bclk_q ^ div_tc;
    bit_cnt_d   = shift_evt ? bit_cnt_q + 6'd1 : bit_cnt_q;
    frame_start = shift_evt && (bit_cnt_q == 6'd63);
  end

  // FIFO control: a strobe into a full buffer is dropped and flagged; a frame start pops the head.
  always_comb begin
    fifo_full  = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);
    push       = new_sample_ready && !fifo_full;
    pop        = frame_start && !fifo_empty;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;
    ovf_d = ovf_q | (new_sample_ready & fifo_full);
    udf_d = udf_q | (frame_start & fifo_empty & play_enable);
  end

  // Request logic: one request in flight at a time; an arriving sample frees the slot for
  // the next request in the same cycle so pacing resumes one cycle after the strobe.
  always_comb begin
    gen_d   = play_enable && (!outst_q || new_sample_ready) && (count_d < DEPTH_C);
    outst_d = outst_q;
    if (gen_d)
      outst_d = 1'b1;
    else if (new_sample_ready)
      outst_d = 1'b0;
  end

  // Serializer: on each shift event present the bit for the new position; slot bits 1..16
  // carry the frame MSB first (one-bit I2S delay), everything else is zero.
  always_comb begin
    frame_d = frame_q;
    if (frame_start)
      frame_d = pop ? mem_q[rd_ptr_q] : 16'sd0;
    slot    = bit_cnt_d[4:0];
    bit_idx = 4'(5'd16 - slot);
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    if (shift_evt) begin
      lrclk_d = bit_cnt_d[5];
      sdata_d = (slot != 5'd0 && slot <= 5'd16) ? frame_d[bit_idx] : 1'b0;
    end
  end

  // Control and output state registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      gen_q     <= 1'b0;
      outst_q   <= 1'b0;
      frame_q   <= '0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      gen_q     <= gen_d;
      outst_q   <= outst_d;
      frame_q   <= frame_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= signed'(sample_in);
  end

  assign generate_next_sample = gen_q;
  assign bclk                 = bclk_q;
  assign lrclk                = lrclk_q;
  assign sdata                = sdata_q;
  assign fifo_count           = count_q;
  assign overflow             = ovf_q;
  assign underflow            = udf_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: an I2S receiver rebuilds each frame from the pins, samples
// handed to the DUT are queued as expected frames, and directed steps compare the two.
module tb_i2s_sample_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play_enable = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        nsr = 1'b0;

  logic        gen, bclk, lrclk, sdata, ovf, udf;
  logic [2:0]  fifo_count;
  logic        gen2, bclk2, lrclk2, sdata2, ovf2, udf2;
  logic [2:0]  fifo_count2;

  always #5 clk = ~clk;

  i2s_sample_tx #(.CLK_DIV(4), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .sample_in(sample_in),
    .new_sample_ready(nsr), .generate_next_sample(gen), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .fifo_count(fifo_count), .overflow(ovf), .underflow(udf)
  );

  i2s_sample_tx #(.CLK_DIV(2), .FIFO_AW(2)) dut2 (
    .clk(clk), .reset(reset), .play_enable(play_enable), .sample_in(sample_in),
    .new_sample_ready(nsr), .generate_next_sample(gen2), .bclk(bclk2), .lrclk(lrclk2),
    .sdata(sdata2), .fifo_count(fifo_count2), .overflow(ovf2), .underflow(udf2)
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        tail;
  } rx_t;

  rx_t         rx_q[$];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          resp_delay = -1;

  // Receiver state
  int          mpos = -1;
  logic        mpb = 1'b0, mplr = 1'b0, mtail = 1'b0, mltail = 1'b0, lenbad = 1'b0;
  logic [15:0] mword = '0, mlw = '0;

  // I2S receiver: sample on bclk rise, one-bit delay after each lrclk change, 32 bits per slot.
  always @(negedge clk) begin
    if (reset) begin
      mpos = -1; mpb = 1'b0; mplr = 1'b0; mword = '0; mtail = 1'b0; lenbad = 1'b0;
      rx_q.delete();
    end else begin
      if (bclk && !mpb) begin
        if (lrclk != mplr) begin
          if (mpos != 31) lenbad = 1'b1;
          mpos = 0;
        end else begin
          mpos++;
          if (mpos > 31) lenbad = 1'b1;
        end
        mplr = lrclk;
        if (mpos == 0) begin
          mword = '0;
          mtail = sdata;
        end else if (mpos <= 16) begin
          mword[16-mpos] = sdata;
        end else if (sdata) begin
          mtail = 1'b1;
        end
        if (mpos == 31) begin
          if (!lrclk) begin
            mlw = mword; mltail = mtail;
          end else begin
            rx_q.push_back('{l: mlw, r: mword, tail: (mltail | mtail)});
          end
        end
      end
      mpb = bclk;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] e);
    rx_t f;
    checks++;
    assert (rx_q.size() > 0) else begin
      failures++;
      $error("FAIL %s: observed no received frame expected one", tag);
    end
    if (rx_q.size() > 0) begin
      f = rx_q.pop_front();
      chk({tag, "_left"},  32'(f.l), 32'(e));
      chk({tag, "_right"}, 32'(f.r), 32'(e));
      chk({tag, "_tail"},  32'(f.tail), 32'(0));
    end
  endtask

  task automatic chk_data_frame(input string tag);
    logic [15:0] e;
    e = 16'h0000;
    chk({tag, "_expq"}, 32'(exp_q.size() > 0), 32'(1));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk_frame(tag, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    nsr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    resp_delay = -1;
  endtask

  // Answer each request three cycles after it is seen; answered samples become expected frames.
  task automatic serve(input int ncyc, input logic [15:0] val);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      nsr = 1'b0;
      if (resp_delay > 0) begin
        resp_delay--;
        if (resp_delay == 0) begin
          nsr = 1'b1;
          sample_in = val;
          exp_q.push_back(val);
          resp_delay = -1;
        end
      end
      if (gen && resp_delay < 0 && !nsr) resp_delay = 3;
    end
    @(negedge clk);
    nsr = 1'b0;
  endtask

  function automatic logic sel_sig(input int sel);
    return (sel == 0) ? bclk2 : lrclk2;
  endfunction

  // Cycles until the selected dut2 signal makes the requested transition; bound+1 on timeout.
  task automatic cycles_to_edge(input int sel, input logic rise, input int bound, output int cyc);
    logic pv;
    pv = sel_sig(sel);
    cyc = bound + 1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (rise ? (!pv && sel_sig(sel)) : (pv && !sel_sig(sel))) begin
        cyc = c;
        break;
      end
      pv = sel_sig(sel);
    end
  endtask

  initial begin
    int n, c, c1, c2, c3;
    logic pb;
    logic [15:0] vals [5];
    vals[0] = 16'h1001; vals[1] = 16'h2002; vals[2] = 16'h3003;
    vals[3] = 16'h4004; vals[4] = 16'h5005;

    // Test 1: reset mid-frame with three samples buffered
    play_enable = 1'b1;
    do_reset();
    serve(100, 16'hBEEF);
    play_enable = 1'b0;
    serve(700, 16'hBEEF);
    chk("t1_count_before_reset", 32'(fifo_count), 32'(3));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_bclk",  32'(bclk), 32'(0));
    chk("t1_async_lrclk", 32'(lrclk), 32'(0));
    chk("t1_async_sdata", 32'(sdata), 32'(0));
    chk("t1_async_gen",   32'(gen), 32'(0));
    chk("t1_async_count", 32'(fifo_count), 32'(0));
    chk("t1_async_flags", 32'({ovf, udf}), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pb = bclk;
    c = 101;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (pb && !bclk) begin c = i; break; end
      pb = bclk;
    end
    chk("t1_first_shift_cycles", 32'(c), 32'(8));
    chk("t1_first_shift_lrclk",  32'(lrclk), 32'(0));
    pb = bclk;
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pb && !bclk) begin
        n++;
        if (lrclk) break;
      end
      pb = bclk;
    end
    chk("t1_shifts_to_right_slot", 32'(n), 32'(32));
    chk("t1_right_slot_lrclk", 32'(lrclk), 32'(1));

    // Test 2: steady play of 0xA5C3
    play_enable = 1'b1;
    do_reset();
    serve(1600, 16'hA5C3);
    chk("t2_frames_received", 32'(rx_q.size()), 32'(3));
    chk_frame("t2_reset_frame", 16'h0000);
    chk_data_frame("t2_frame1");
    chk_data_frame("t2_frame2");
    chk("t2_slot_length", 32'(lenbad), 32'(0));
    chk("t2_no_overflow", 32'(ovf), 32'(0));
    chk("t2_no_underflow", 32'(udf), 32'(0));

    // Test 3: one request outstanding, resumes right after the answer
    play_enable = 1'b1;
    do_reset();
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (gen) n++;
    end
    chk("t3_single_request", 32'(n), 32'(1));
    @(negedge clk);
    chk("t3_gen_before_answer", 32'(gen), 32'(0));
    nsr = 1'b1;
    sample_in = 16'h1234;
    @(negedge clk);
    nsr = 1'b0;
    chk("t3_gen_resumes", 32'(gen), 32'(1));
    @(negedge clk);
    chk("t3_gen_one_cycle", 32'(gen), 32'(0));
    play_enable = 1'b0;

    // Test 4: five unsolicited samples into a four-entry buffer
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nsr = 1'b1;
      sample_in = vals[k];
      if (k < 4) exp_q.push_back(vals[k]);
    end
    @(negedge clk);
    nsr = 1'b0;
    chk("t4_count_full", 32'(fifo_count), 32'(4));
    chk("t4_overflow", 32'(ovf), 32'(1));
    repeat (3100) @(negedge clk);
    chk("t4_frames_received", 32'(rx_q.size()), 32'(6));
    chk_frame("t4_reset_frame", 16'h0000);
    for (int k = 0; k < 4; k++) chk_data_frame($sformatf("t4_frame%0d", k + 1));
    chk_frame("t4_drained_frame", 16'h0000);
    chk("t4_count_empty", 32'(fifo_count), 32'(0));
    chk("t4_no_underflow", 32'(udf), 32'(0));
    chk("t4_overflow_sticky", 32'(ovf), 32'(1));
    chk("t4_slot_length", 32'(lenbad), 32'(0));

    // Test 5: empty frame starts with and without play_enable
    play_enable = 1'b1;
    do_reset();
    repeat (400) @(negedge clk);
    chk("t5_reset_frame_no_underflow", 32'(udf), 32'(0));
    repeat (700) @(negedge clk);
    chk("t5_underflow_set", 32'(udf), 32'(1));
    chk("t5_frames_received", 32'(rx_q.size()), 32'(2));
    chk_frame("t5_frame0", 16'h0000);
    chk_frame("t5_frame1", 16'h0000);
    play_enable = 1'b0;
    do_reset();
    repeat (1100) @(negedge clk);
    chk("t5_idle_underflow_clear", 32'(udf), 32'(0));
    chk_frame("t5_idle_frame0", 16'h0000);
    chk_frame("t5_idle_frame1", 16'h0000);

    // Test 6: CLK_DIV=2 timing on the second instance
    do_reset();
    cycles_to_edge(0, 1'b1, 50, c);
    chk("t6_bclk_found", 32'(c <= 50), 32'(1));
    cycles_to_edge(0, 1'b1, 50, c);
    chk("t6_bclk_period", 32'(c), 32'(4));
    cycles_to_edge(1, 1'b0, 600, c);
    chk("t6_lrclk_found", 32'(c <= 600), 32'(1));
    cycles_to_edge(1, 1'b0, 600, c1);
    cycles_to_edge(1, 1'b0, 600, c2);
    cycles_to_edge(1, 1'b0, 600, c3);
    chk("t6_three_frames", 32'(c1 + c2 + c3), 32'(768));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_sample_tx.md
Name: i2s_sample_tx

Overview:
Downstream stage of notes_player. Accepts 16-bit audio samples on the sample_out/new_sample_ready interface, buffers them in a small FIFO, and paces the player by pulsing generate_next_sample whenever buffer space is available. Serializes each buffered sample as a standard I2S frame with the same sample on left and right. Drives the codec DAC pins.

Parameters:
CLK_DIV, 4, clk cycles per half bit-clock period (bclk period = 2*CLK_DIV clk cycles); legal values 2..255.
FIFO_AW, 2, FIFO address width (depth = 2**FIFO_AW = 4).

Ports:
clk  input  1  system clock; all logic rises on posedge clk.
reset  input  1  asynchronous, active-high reset.
play_enable  input  1  permits new sample requests.
sample_in  input  16  signed sample from notes_player sample_out.
new_sample_ready  input  1  one-cycle strobe; sample_in is valid this cycle.
generate_next_sample  output  1  one-cycle request pulse to notes_player.
bclk  output  1  I2S bit clock, registered.
lrclk  output  1  I2S word select, registered; 0 = left, 1 = right.
sdata  output  1  I2S serial data, registered.
fifo_count  output  FIFO_AW+1  current FIFO occupancy.
overflow  output  1  sticky: sample dropped because FIFO was full.
underflow  output  1  sticky: frame start found FIFO empty while play_enable=1.

Behaviour:
- Reset (async, active-high): bclk=0, lrclk=0, sdata=0, generate_next_sample=0, fifo_count=0, overflow=0, underflow=0. Divider, bit counter, outstanding flag, and shift register are cleared. Reset mid-frame abandons the frame. The first frame after reset starts at bit 0.
- Request logic:
  - generate_next_sample pulses for exactly 1 cycle when play_enable=1, outstanding=0, and fifo_count + 1 <= depth (counting a pop in the same cycle is not required).
  - The pulse sets outstanding. outstanding clears on the cycle new_sample_ready=1.
  - No second request is issued while outstanding=1.
- FIFO write: on new_sample_ready=1 with FIFO not full, write sample_in. If full, drop the sample and set overflow.
- Divider: counter 0..CLK_DIV-1. On terminal count bclk toggles and the counter wraps.
- Falling edge of bclk (1->0 toggle) is the "shift event". bit_cnt (6 bits, 0..63) increments at each shift event and wraps 63->0.
- Frame start: the shift event where bit_cnt becomes 0.
  - If the FIFO is non-empty, pop the head into the frame register.
  - If empty, load 0; underflow is set only if play_enable=1.
- Outputs updated at each shift event, using the new bit_cnt:
  - lrclk = bit_cnt[5].
  - slot_bit = bit_cnt[4:0].
  - sdata = frame[16-slot_bit] for slot_bit 1..16; else 0. This gives the I2S one-bit delay, MSB first.
  - Left slot (bit_cnt 0..31) and right slot (32..63) carry the same frame register.
- Timing: frame = 64 bclk = 128*CLK_DIV clk cycles (512 at default). bclk, lrclk, and sdata change only on clk edges and never glitch.
- Simultaneous FIFO write and pop in the same cycle: both happen and fifo_count is unchanged. Pop from empty and push to full never occur.
- play_enable=0:
  - No new requests are issued. An outstanding request may still complete.
  - The serializer keeps running and drains the FIFO.
  - Empty frames output zeros.
- overflow and underflow stay set until reset.

Test Plan:
1. Assert reset mid-frame with FIFO holding 3 samples -> all outputs 0 and fifo_count=0 asynchronously. The first shift event after release gives bit_cnt=1 with lrclk=0.
2. play_enable=1, respond to each request 3 cycles later with sample 0xA5C3 -> left-slot sdata over bit_cnt 1..16 = 1010_0101_1100_0011. bit_cnt 17..31 = 0. Right slot repeats the pattern. lrclk toggles every 32 bclk.
3. Never answer the first request -> exactly one generate_next_sample pulse. It never repeats while outstanding. It resumes 1 cycle after new_sample_ready.
4. Inject 5 unsolicited new_sample_ready strobes back-to-back with no frame start -> fifo_count saturates at 4, overflow=1, and the 5th sample never appears on sdata.
5. play_enable=1 with requests unanswered through a frame start -> that frame is all zeros and underflow=1. Repeat with play_enable=0 -> zeros and underflow stays 0.
6. CLK_DIV=2 -> bclk period 4 clk cycles and frame period 256 clk cycles, measured over 3 frames.
